// File: rtl/amba_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : amba_rd_ctrl
//  Description : Read-side controller for the three packet-router output
//                channels. Presents FWFT RAM data to the reader, pops on
//                read_enb, tracks header/payload/parity framing per channel
//                and issues a soft reset when a reader stalls for TIMEOUT
//                cycles.
//                Optional: define RD_PARITY_CHECK_EN to enable the per-channel
//                parity accumulator and par_err pulse; when undefined the
//                par_err outputs are held at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module amba_rd_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          ram_empty_0,
  input  logic          ram_empty_1,
  input  logic          ram_empty_2,
  input  logic [DW-1:0] dout_0,
  input  logic [DW-1:0] dout_1,
  input  logic [DW-1:0] dout_2,
  input  logic          read_enb_0,
  input  logic          read_enb_1,
  input  logic          read_enb_2,
  output logic          vld_out_0,
  output logic          vld_out_1,
  output logic          vld_out_2,
  output logic          ram_rd_0,
  output logic          ram_rd_1,
  output logic          ram_rd_2,
  output logic          soft_reset_0,
  output logic          soft_reset_1,
  output logic          soft_reset_2,
  output logic          pkt_end_0,
  output logic          pkt_end_1,
  output logic          pkt_end_2,
  output logic          rd_busy_0,
  output logic          rd_busy_1,
  output logic          rd_busy_2,
  output logic          par_err_0,
  output logic          par_err_1,
  output logic          par_err_2
);

  localparam int NCH = 3;
  // Width of the remaining-payload counter (length field of an 8-bit header)
  localparam int RW  = 6;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    PAY = 2'd1,
    PAR = 2'd2
  } trk_state_t;

  logic [NCH-1:0] w_empty;
  logic [NCH-1:0] w_renb;
  logic [NCH-1:0] w_vld;
  logic [NCH-1:0] w_rd;
  logic [NCH-1:0] w_soft;
  logic [NCH-1:0] w_pend;
  logic [NCH-1:0] w_perr;
  logic [NCH-1:0] w_busy;
  logic [DW-1:0]  w_dout [NCH];

  assign w_empty   = {ram_empty_2, ram_empty_1, ram_empty_0};
  assign w_renb    = {read_enb_2, read_enb_1, read_enb_0};
  assign w_dout[0] = dout_0;
  assign w_dout[1] = dout_1;
  assign w_dout[2] = dout_2;

  // A byte is offered only when present and the channel is not being flushed
  assign w_vld = ~w_empty & ~w_soft;
  assign w_rd  = w_renb & w_vld;

  assign {vld_out_2, vld_out_1, vld_out_0}          = w_vld;
  assign {ram_rd_2, ram_rd_1, ram_rd_0}             = w_rd;
  assign {soft_reset_2, soft_reset_1, soft_reset_0} = w_soft;
  assign {pkt_end_2, pkt_end_1, pkt_end_0}          = w_pend;
  assign {rd_busy_2, rd_busy_1, rd_busy_0}          = w_busy;
  assign {par_err_2, par_err_1, par_err_0}          = w_perr;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             soft_q;
      logic             soft_d;
      trk_state_t       state_q;
      logic [RW-1:0]    remain_q;
      logic [RW-1:0]    len;
      logic             pkt_end_q;
      logic             par_err_q;

      // Length field of the header currently at the RAM head
      assign len = RW'(w_dout[g][DW-1:2]);

      // Stall counter: counts cycles with data offered but not taken
      always_comb begin
        cnt_d  = '0;
        soft_d = 1'b0;
        if (w_vld[g] && !w_renb[g]) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            soft_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Register the stall count and the one-cycle soft reset pulse
      always_ff @(posedge clock) begin
        if (!resetn) begin
          cnt_q  <= '0;
          soft_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          soft_q <= soft_d;
        end
      end

`ifdef RD_PARITY_CHECK_EN
      logic [DW-1:0] acc_q;

      // Running XOR of header and payload bytes, checked at the parity byte
      always_ff @(posedge clock) begin
        if (!resetn || soft_q) begin
          acc_q <= '0;
        end else if (w_rd[g]) begin
          case (state_q)
            HDR:     acc_q <= w_dout[g];
            PAY:     acc_q <= acc_q ^ w_dout[g];
            default: acc_q <= '0;
          endcase
        end
      end
`else
      // Low header bits only feed the parity accumulator, absent in this build
      logic unused_dout_lo;
      assign unused_dout_lo = ^w_dout[g][1:0];
`endif

      // Framing tracker: header -> payload bytes -> parity, advancing on reads
      always_ff @(posedge clock) begin
        if (!resetn) begin
          state_q   <= HDR;
          remain_q  <= '0;
          pkt_end_q <= 1'b0;
          par_err_q <= 1'b0;
        end else begin
          pkt_end_q <= 1'b0;
          par_err_q <= 1'b0;
          if (soft_q) begin
            state_q  <= HDR;
            remain_q <= '0;
          end else if (w_rd[g]) begin
            case (state_q)
              HDR: begin
                remain_q <= len;
                state_q  <= (len == '0) ? PAR : PAY;
              end
              PAY: begin
                remain_q <= remain_q - RW'(1);
                if (remain_q == RW'(1)) begin
                  state_q <= PAR;
                end
              end
              PAR: begin
                pkt_end_q <= 1'b1;
`ifdef RD_PARITY_CHECK_EN
                par_err_q <= (acc_q != w_dout[g]);
`endif
                state_q   <= HDR;
              end
              default: state_q <= HDR;
            endcase
          end
        end
      end

      assign w_soft[g] = soft_q;
      assign w_pend[g] = pkt_end_q;
      assign w_perr[g] = par_err_q;
      assign w_busy[g] = (state_q != HDR);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_amba_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amba_rd_ctrl
//  Description : Self-checking bench for amba_rd_ctrl. Byte streams per
//                channel feed the DUT; a packet-level reference model predicts
//                every output each cycle. Honours RD_PARITY_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_amba_rd_ctrl;

  localparam int DW      = 8;
  localparam int TIMEOUT = 30;
  localparam int NCH     = 3;
`ifdef RD_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [2:0]    ram_empty = 3'b111;
  logic [2:0]    read_enb = 3'b000;
  logic [DW-1:0] dout [NCH];
  wire           vld_out_0, vld_out_1, vld_out_2;
  wire           ram_rd_0, ram_rd_1, ram_rd_2;
  wire           soft_reset_0, soft_reset_1, soft_reset_2;
  wire           pkt_end_0, pkt_end_1, pkt_end_2;
  wire           rd_busy_0, rd_busy_1, rd_busy_2;
  wire           par_err_0, par_err_1, par_err_2;

  always #5 clock = ~clock;

  amba_rd_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn),
    .ram_empty_0(ram_empty[0]), .ram_empty_1(ram_empty[1]), .ram_empty_2(ram_empty[2]),
    .dout_0(dout[0]), .dout_1(dout[1]), .dout_2(dout[2]),
    .read_enb_0(read_enb[0]), .read_enb_1(read_enb[1]), .read_enb_2(read_enb[2]),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .ram_rd_0(ram_rd_0), .ram_rd_1(ram_rd_1), .ram_rd_2(ram_rd_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .pkt_end_0(pkt_end_0), .pkt_end_1(pkt_end_1), .pkt_end_2(pkt_end_2),
    .rd_busy_0(rd_busy_0), .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .par_err_0(par_err_0), .par_err_1(par_err_1), .par_err_2(par_err_2)
  );

  wire [2:0] vld_v  = {vld_out_2, vld_out_1, vld_out_0};
  wire [2:0] rd_v   = {ram_rd_2, ram_rd_1, ram_rd_0};
  wire [2:0] soft_v = {soft_reset_2, soft_reset_1, soft_reset_0};
  wire [2:0] pend_v = {pkt_end_2, pkt_end_1, pkt_end_0};
  wire [2:0] busy_v = {rd_busy_2, rd_busy_1, rd_busy_0};
  wire [2:0] perr_v = {par_err_2, par_err_1, par_err_0};

  int n_checks = 0;
  int n_errors = 0;

  // Per-channel byte streams standing in for the channel RAMs
  logic [7:0] sbuf [NCH][1024];
  int         rp [NCH];
  int         wp [NCH];
  bit         hold [NCH];

  // Packet-level reference model
  bit         m_soft [NCH];
  bit         m_pend [NCH];
  bit         m_perr [NCH];
  int         m_stall [NCH];
  int         m_pos [NCH];
  int         m_len [NCH];
  logic [7:0] m_xor [NCH];

  // Values observed in the most recent cycle
  logic o_vld [NCH];
  logic o_rd [NCH];
  logic o_soft [NCH];
  logic o_pend [NCH];
  logic o_perr [NCH];
  logic o_busy [NCH];

  task automatic push_byte(input int c, input logic [7:0] b);
    sbuf[c][wp[c] % 1024] = b;
    wp[c]++;
  endtask

  task automatic push_packet(input int c, input int len, input bit corrupt);
    logic [7:0] b;
    logic [7:0] x;
    b = {6'(len), 2'($urandom)};
    x = b;
    push_byte(c, b);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      push_byte(c, b);
    end
    push_byte(c, x ^ {7'd0, corrupt});
  endtask

  // One clock cycle: present stream heads, compare against model, advance both
  task automatic run_cycle(input bit rst);
    bit         e_vld, e_rd, n_soft, n_pend, n_perr;
    logic [7:0] d;
    resetn = !rst;
    for (int c = 0; c < NCH; c++) begin
      ram_empty[c] = hold[c] || (rp[c] == wp[c]);
      dout[c] = ram_empty[c] ? 8'($urandom) : sbuf[c][rp[c] % 1024];
    end
    #1;
    for (int c = 0; c < NCH; c++) begin
      e_vld = !ram_empty[c] && !m_soft[c];
      e_rd  = read_enb[c] && e_vld;
      d     = dout[c];
      o_vld[c] = vld_v[c]; o_rd[c] = rd_v[c]; o_soft[c] = soft_v[c];
      o_pend[c] = pend_v[c]; o_perr[c] = perr_v[c]; o_busy[c] = busy_v[c];
      n_checks += 6;
      if (o_vld[c] !== e_vld) begin n_errors++; $display("FAIL ch%0d vld_out got %0b want %0b at %0t", c, o_vld[c], e_vld, $time); end
      if (o_rd[c] !== e_rd) begin n_errors++; $display("FAIL ch%0d ram_rd got %0b want %0b at %0t", c, o_rd[c], e_rd, $time); end
      if (o_soft[c] !== m_soft[c]) begin n_errors++; $display("FAIL ch%0d soft_reset got %0b want %0b at %0t", c, o_soft[c], m_soft[c], $time); end
      if (o_pend[c] !== m_pend[c]) begin n_errors++; $display("FAIL ch%0d pkt_end got %0b want %0b at %0t", c, o_pend[c], m_pend[c], $time); end
      if (o_perr[c] !== m_perr[c]) begin n_errors++; $display("FAIL ch%0d par_err got %0b want %0b at %0t", c, o_perr[c], m_perr[c], $time); end
      if (o_busy[c] !== (m_pos[c] != 0)) begin n_errors++; $display("FAIL ch%0d rd_busy got %0b want %0b at %0t", c, o_busy[c], (m_pos[c] != 0), $time); end

      // Stream side: a soft reset flushes the RAM, otherwise pop on read
      if (m_soft[c]) rp[c] = wp[c];
      else if (e_rd) rp[c]++;

      n_soft = 1'b0; n_pend = 1'b0; n_perr = 1'b0;
      if (rst) begin
        m_stall[c] = 0; m_pos[c] = 0; m_len[c] = 0; m_xor[c] = 8'h00;
      end else begin
        if (!e_vld || read_enb[c]) m_stall[c] = 0;
        else begin
          m_stall[c]++;
          if (m_stall[c] == TIMEOUT) begin m_stall[c] = 0; n_soft = 1'b1; end
        end
        if (m_soft[c]) begin
          m_pos[c] = 0; m_xor[c] = 8'h00;
        end else if (e_rd) begin
          if (m_pos[c] == 0) begin
            m_len[c] = int'(d >> 2); m_xor[c] = d; m_pos[c] = 1;
          end else if (m_pos[c] <= m_len[c]) begin
            m_xor[c] = m_xor[c] ^ d; m_pos[c]++;
          end else begin
            n_pend = 1'b1; n_perr = PAR_EN && (m_xor[c] != d);
            m_pos[c] = 0; m_xor[c] = 8'h00;
          end
        end
      end
      m_soft[c] = n_soft; m_pend[c] = n_pend; m_perr[c] = n_perr;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    read_enb = 3'b000;
    for (int c = 0; c < NCH; c++) begin hold[c] = 1'b0; rp[c] = wp[c]; end
    run_cycle(1'b1);
    run_cycle(1'b0);
  endtask

  task automatic test_reset();
    read_enb = 3'b000;
    for (int c = 0; c < NCH; c++) begin hold[c] = 1'b0; rp[c] = wp[c]; end
    push_byte(0, 8'h10);
    run_cycle(1'b1);
    n_checks += 3;
    if (o_vld[0] !== 1'b1) begin n_errors++; $display("FAIL reset_vld_nonempty got %0b want 1", o_vld[0]); end
    if (o_vld[1] !== 1'b0) begin n_errors++; $display("FAIL reset_vld_empty got %0b want 0", o_vld[1]); end
    if (o_busy[0] !== 1'b0 || o_soft[0] !== 1'b0) begin n_errors++; $display("FAIL reset_state busy=%0b soft=%0b want 0,0", o_busy[0], o_soft[0]); end
    rp[0] = wp[0];
  endtask

  task automatic test_packet(input bit corrupt);
    logic [8:0] busy_r, pend_r, perr_r;
    int         reads;
    logic [8:0] perr_want;
    do_reset();
    push_byte(0, 8'h0C); push_byte(0, 8'h01); push_byte(0, 8'h02); push_byte(0, 8'h03);
    push_byte(0, corrupt ? 8'h0D : 8'h0C);
    read_enb = 3'b001;
    busy_r = '0; pend_r = '0; perr_r = '0; reads = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      run_cycle(1'b0);
      busy_r[cyc] = o_busy[0]; pend_r[cyc] = o_pend[0]; perr_r[cyc] = o_perr[0];
      if (o_rd[0] === 1'b1) reads++;
    end
    perr_want = (corrupt && PAR_EN) ? 9'h040 : 9'h000;
    n_checks += 4;
    if (reads != 5) begin n_errors++; $display("FAIL pkt_reads got %0d want 5", reads); end
    if (busy_r !== 9'h03C) begin n_errors++; $display("FAIL pkt_busy got %h want 03c", busy_r); end
    if (pend_r !== 9'h040) begin n_errors++; $display("FAIL pkt_end got %h want 040", pend_r); end
    if (perr_r !== perr_want) begin n_errors++; $display("FAIL pkt_par_err got %h want %h", perr_r, perr_want); end
  endtask

  task automatic test_timeout();
    logic [63:0] soft_r;
    logic        vld31, busy32;
    do_reset();
    push_packet(1, 3, 1'b0);
    read_enb = 3'b000;
    soft_r = '0; vld31 = 1'bx; busy32 = 1'bx;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      run_cycle(1'b0);
      soft_r[cyc] = o_soft[1];
      if (cyc == 31) vld31 = o_vld[1];
      if (cyc == 32) busy32 = o_busy[1];
    end
    n_checks += 3;
    if (soft_r !== (64'd1 << 31)) begin n_errors++; $display("FAIL timeout_soft got %h want %h", soft_r, 64'd1 << 31); end
    if (vld31 !== 1'b0) begin n_errors++; $display("FAIL timeout_vld got %0b want 0", vld31); end
    if (busy32 !== 1'b0) begin n_errors++; $display("FAIL timeout_busy got %0b want 0", busy32); end
  endtask

  task automatic test_timeout_rescue();
    logic [127:0] soft_r;
    logic         busy61, busy62;
    do_reset();
    push_packet(1, 5, 1'b0);
    soft_r = '0; busy61 = 1'bx; busy62 = 1'bx;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      read_enb = (cyc == 30) ? 3'b010 : 3'b000;
      run_cycle(1'b0);
      soft_r[cyc] = o_soft[1];
      if (cyc == 61) busy61 = o_busy[1];
      if (cyc == 62) busy62 = o_busy[1];
    end
    n_checks += 3;
    if (soft_r !== (128'd1 << 61)) begin n_errors++; $display("FAIL rescue_soft got %h want %h", soft_r, 128'd1 << 61); end
    if (busy61 !== 1'b1) begin n_errors++; $display("FAIL rescue_busy_before got %0b want 1", busy61); end
    if (busy62 !== 1'b0) begin n_errors++; $display("FAIL rescue_busy_after got %0b want 0", busy62); end
  endtask

  task automatic test_zero_len();
    logic [7:0] busy_r, pend_r;
    int         reads;
    do_reset();
    push_byte(2, 8'h00); push_byte(2, 8'h00);
    read_enb = 3'b100;
    busy_r = '0; pend_r = '0; reads = 0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      run_cycle(1'b0);
      busy_r[cyc] = o_busy[2]; pend_r[cyc] = o_pend[2];
      if (o_rd[2] === 1'b1) reads++;
    end
    n_checks += 3;
    if (reads != 2) begin n_errors++; $display("FAIL zlen_reads got %0d want 2", reads); end
    if (busy_r !== 8'h04) begin n_errors++; $display("FAIL zlen_busy got %h want 04", busy_r); end
    if (pend_r !== 8'h08) begin n_errors++; $display("FAIL zlen_pkt_end got %h want 08", pend_r); end
  endtask

  task automatic test_concurrent_reset();
    logic [63:0] soft_r [NCH];
    bit          any_pend;
    logic [2:0]  busy6;
    do_reset();
    for (int c = 0; c < NCH; c++) begin push_packet(c, 10, 1'b0); soft_r[c] = '0; end
    read_enb = 3'b111;
    any_pend = 1'b0; busy6 = 3'bxxx;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (cyc == 6) begin
        read_enb = 3'b000;
        for (int c = 0; c < NCH; c++) hold[c] = 1'b1;
      end
      if (cyc == 8) for (int c = 0; c < NCH; c++) hold[c] = 1'b0;
      run_cycle(cyc == 5);
      for (int c = 0; c < NCH; c++) begin
        soft_r[c][cyc] = o_soft[c];
        if (cyc >= 5 && o_pend[c] !== 1'b0) any_pend = 1'b1;
        if (cyc == 6) busy6[c] = o_busy[c];
      end
    end
    n_checks += 2 + NCH;
    if (any_pend) begin n_errors++; $display("FAIL creset_pkt_end got 1 want 0"); end
    if (busy6 !== 3'b000) begin n_errors++; $display("FAIL creset_busy got %b want 000", busy6); end
    for (int c = 0; c < NCH; c++)
      if (soft_r[c] !== (64'd1 << 38)) begin n_errors++; $display("FAIL creset_cnt ch%0d soft got %h want %h", c, soft_r[c], 64'd1 << 38); end
  endtask

  task automatic test_random();
    bit busy_phase;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      busy_phase = ((cyc / 500) % 2) == 0;
      for (int c = 0; c < NCH; c++) begin
        if ((wp[c] - rp[c]) < 16) push_packet(c, int'($urandom_range(0, 12)), $urandom_range(0, 3) == 0);
        if (busy_phase) begin
          read_enb[c] = ($urandom_range(0, 99) < 70);
          hold[c]     = ($urandom_range(0, 99) < 10);
        end else begin
          read_enb[c] = ($urandom_range(0, 99) < 2);
          hold[c]     = ($urandom_range(0, 99) < 1);
        end
      end
      run_cycle($urandom_range(0, 399) == 0);
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      rp[c] = 0; wp[c] = 0; hold[c] = 1'b0; dout[c] = 8'h00;
      m_soft[c] = 1'b0; m_pend[c] = 1'b0; m_perr[c] = 1'b0;
      m_stall[c] = 0; m_pos[c] = 0; m_len[c] = 0; m_xor[c] = 8'h00;
    end
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_packet(1'b0);
    test_packet(1'b1);
    test_timeout();
    test_timeout_rescue();
    test_zero_len();
    test_concurrent_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
